mmult_opt_mdc_engine_ctrl: RTL and testbench

MMULT_OPT_MDC_ENGINE_CTRL -- requirements
Module: mmult_opt_mdc_engine_ctrl

---
 rtl/mmult_opt_mdc_engine_ctrl_pkg.sv | 19 +
 rtl/mmult_opt_mdc_engine_ctrl.sv | 73 +++++++
 tb/tb_mmult_opt_mdc_engine_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mmult_opt_mdc_engine_ctrl_pkg.sv
// mmult_opt_mdc_engine_ctrl_pkg: shared accelerator types for the engine control block.
package mmult_opt_mdc_engine_ctrl_pkg;

   localparam int unsigned CNT_WIDTH_DEF = 32;

   typedef enum logic [1:0] {IDLE, RUN, DONE} ctrl_state_e;

   typedef struct packed {
      logic clear;
      logic enable;
      logic start;
   } engine_ctrl_t;

   typedef struct packed {
      logic ready;
      logic done;
   } engine_flags_t;

endpackage

// File: rtl/mmult_opt_mdc_engine_ctrl.sv
// mmult_opt_mdc_engine_ctrl: job FSM that gates the in1/in2/out_r streams and counts out_r beats.
module mmult_opt_mdc_engine_ctrl
   import mmult_opt_mdc_engine_ctrl_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 enable_i,
   input  logic                 start_i,
   input  logic [CNT_WIDTH-1:0] cnt_limit_i,
   input  logic                 in1_s_valid_i,
   output logic                 in1_s_ready_o,
   output logic                 in1_k_valid_o,
   input  logic                 in1_k_ready_i,
   input  logic                 in2_s_valid_i,
   output logic                 in2_s_ready_o,
   output logic                 in2_k_valid_o,
   input  logic                 in2_k_ready_i,
   input  logic                 out_k_valid_i,
   output logic                 out_k_ready_o,
   output logic                 out_s_valid_o,
   input  logic                 out_s_ready_i,
   output logic                 out_s_last_o,
   output logic [CNT_WIDTH-1:0] cnt_out_r_o,
   output logic                 ready_o,
   output logic                 done_o
);

   ctrl_state_e          state_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 gate;
   logic                 beat;
   logic                 at_last;

   assign gate    = (state_q == RUN) & enable_i;
   assign beat    = gate & out_k_valid_i & out_s_ready_i;
   assign at_last = cnt_q == cnt_limit_i - CNT_WIDTH'(1);

   assign in1_k_valid_o = gate & in1_s_valid_i;
   assign in1_s_ready_o = gate & in1_k_ready_i;
   assign in2_k_valid_o = gate & in2_s_valid_i;
   assign in2_s_ready_o = gate & in2_k_ready_i;
   assign out_s_valid_o = gate & out_k_valid_i;
   assign out_k_ready_o = gate & out_s_ready_i;
   assign out_s_last_o  = gate & out_k_valid_i & at_last;

   assign cnt_out_r_o = cnt_q;
   assign ready_o     = state_q == IDLE;
   assign done_o      = state_q == DONE;

   // The counter survives across jobs; only clear or reset zeroes it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else if (clear_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (start_i & enable_i) state_q <= (cnt_q < cnt_limit_i) ? RUN : DONE;
            RUN: if (beat) begin
               cnt_q <= (cnt_q < cnt_limit_i) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
               if (at_last) state_q <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mmult_opt_mdc_engine_ctrl.sv
// tb_mmult_opt_mdc_engine_ctrl: directed-vector bench for the engine control FSM.
module tb_mmult_opt_mdc_engine_ctrl;

   localparam int W = 32;

   logic         clk_i = 1'b0;
   logic         rst_ni, clear_i, enable_i, start_i;
   logic [W-1:0] cnt_limit_i;
   logic         in1_s_valid_i, in1_s_ready_o, in1_k_valid_o, in1_k_ready_i;
   logic         in2_s_valid_i, in2_s_ready_o, in2_k_valid_o, in2_k_ready_i;
   logic         out_k_valid_i, out_k_ready_o, out_s_valid_o, out_s_ready_i, out_s_last_o;
   logic [W-1:0] cnt_out_r_o;
   logic         ready_o, done_o;
   logic [5:0]   fwd;

   int vecs = 0;
   int errs = 0;

   always #5 clk_i = ~clk_i;

   assign fwd = {in1_k_valid_o, in1_s_ready_o, in2_k_valid_o, in2_s_ready_o, out_s_valid_o, out_k_ready_o};

   mmult_opt_mdc_engine_ctrl #(.CNT_WIDTH(W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i), .start_i(start_i),
      .cnt_limit_i(cnt_limit_i),
      .in1_s_valid_i(in1_s_valid_i), .in1_s_ready_o(in1_s_ready_o),
      .in1_k_valid_o(in1_k_valid_o), .in1_k_ready_i(in1_k_ready_i),
      .in2_s_valid_i(in2_s_valid_i), .in2_s_ready_o(in2_s_ready_o),
      .in2_k_valid_o(in2_k_valid_o), .in2_k_ready_i(in2_k_ready_i),
      .out_k_valid_i(out_k_valid_i), .out_k_ready_o(out_k_ready_o),
      .out_s_valid_o(out_s_valid_o), .out_s_ready_i(out_s_ready_i), .out_s_last_o(out_s_last_o),
      .cnt_out_r_o(cnt_out_r_o), .ready_o(ready_o), .done_o(done_o)
   );

   task automatic all_valid(input logic v);
      in1_s_valid_i = v; in1_k_ready_i = v;
      in2_s_valid_i = v; in2_k_ready_i = v;
      out_k_valid_i = v; out_s_ready_i = v;
   endtask

   task automatic clr;
      @(negedge clk_i); clear_i = 1'b1; start_i = 1'b0; enable_i = 1'b1; all_valid(1'b0);
      @(negedge clk_i); clear_i = 1'b0;
   endtask

   task automatic start_job(input logic [W-1:0] lim);
      @(negedge clk_i); cnt_limit_i = lim; start_i = 1'b1;
   endtask

   task automatic test_reset;
      rst_ni = 1'b0; clear_i = 1'b0; enable_i = 1'b1; start_i = 1'b0; cnt_limit_i = 4;
      all_valid(1'b1);
      #12;
      vecs++; if (ready_o !== 1'b1) begin errs++; $display("FAIL reset_ready got %b exp 1", ready_o); end
      vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL reset_done got %b exp 0", done_o); end
      vecs++; if (cnt_out_r_o !== 0) begin errs++; $display("FAIL reset_cnt got %0d exp 0", cnt_out_r_o); end
      vecs++; if (fwd !== 6'h00) begin errs++; $display("FAIL reset_fwd got %h exp 00", fwd); end
      @(negedge clk_i); rst_ni = 1'b1; all_valid(1'b0);
   endtask

   task automatic test_basic;
      clr();
      start_job(4); all_valid(1'b1); #1;
      vecs++; if (fwd !== 6'h00) begin errs++; $display("FAIL basic_idle_fwd got %h exp 00", fwd); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i); start_i = 1'b0; #1;
         vecs++; if (cnt_out_r_o !== i) begin errs++; $display("FAIL basic_cnt%0d got %0d exp %0d", i, cnt_out_r_o, i); end
         vecs++; if (out_s_last_o !== (i == 3)) begin errs++; $display("FAIL basic_last%0d got %b exp %b", i, out_s_last_o, i == 3); end
         vecs++; if (fwd !== 6'h3f || ready_o !== 1'b0) begin errs++; $display("FAIL basic_fwd%0d got %h/%b exp 3f/0", i, fwd, ready_o); end
      end
      @(negedge clk_i); #1;
      vecs++; if (done_o !== 1'b1 || cnt_out_r_o !== 4) begin errs++; $display("FAIL basic_done got %b/%0d exp 1/4", done_o, cnt_out_r_o); end
      vecs++; if (fwd !== 6'h00 || out_s_last_o !== 1'b0) begin errs++; $display("FAIL basic_done_fwd got %h/%b exp 00/0", fwd, out_s_last_o); end
      @(negedge clk_i); #1;
      vecs++; if (done_o !== 1'b0 || ready_o !== 1'b1 || cnt_out_r_o !== 4) begin errs++; $display("FAIL basic_idle got done %b ready %b cnt %0d exp 0/1/4", done_o, ready_o, cnt_out_r_o); end
   endtask

   task automatic test_limit0;
      clr();
      start_job(0); all_valid(1'b1); #1;
      vecs++; if (fwd !== 6'h00 || done_o !== 1'b0) begin errs++; $display("FAIL lim0_idle got %h/%b exp 00/0", fwd, done_o); end
      @(negedge clk_i); start_i = 1'b0; #1;
      vecs++; if (done_o !== 1'b1 || cnt_out_r_o !== 0) begin errs++; $display("FAIL lim0_done got %b/%0d exp 1/0", done_o, cnt_out_r_o); end
      vecs++; if (fwd !== 6'h00 || out_s_last_o !== 1'b0) begin errs++; $display("FAIL lim0_fwd got %h/%b exp 00/0", fwd, out_s_last_o); end
      @(negedge clk_i); #1;
      vecs++; if (done_o !== 1'b0 || ready_o !== 1'b1) begin errs++; $display("FAIL lim0_back got %b/%b exp 0/1", done_o, ready_o); end
   endtask

   task automatic test_backpressure;
      clr();
      start_job(3);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i); start_i = 1'b0; out_k_valid_i = 1'b1; out_s_ready_i = (k % 2 == 0); #1;
         vecs++; if (cnt_out_r_o !== (k + 1) / 2) begin errs++; $display("FAIL bp_cnt%0d got %0d exp %0d", k, cnt_out_r_o, (k + 1) / 2); end
         vecs++; if (out_k_ready_o !== (k % 2 == 0) || out_s_valid_o !== 1'b1) begin errs++; $display("FAIL bp_hs%0d got %b/%b exp %b/1", k, out_k_ready_o, out_s_valid_o, k % 2 == 0); end
         vecs++; if (out_s_last_o !== (k >= 3)) begin errs++; $display("FAIL bp_last%0d got %b exp %b", k, out_s_last_o, k >= 3); end
      end
      @(negedge clk_i); #1;
      vecs++; if (done_o !== 1'b1 || cnt_out_r_o !== 3) begin errs++; $display("FAIL bp_done got %b/%0d exp 1/3", done_o, cnt_out_r_o); end
   endtask

   task automatic test_enable_pause;
      clr();
      start_job(4); all_valid(1'b1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i); start_i = 1'b0; #1;
         vecs++; if (cnt_out_r_o !== k) begin errs++; $display("FAIL en_pre%0d got %0d exp %0d", k, cnt_out_r_o, k); end
      end
      for (int j = 0; j < 5; j++) begin
         @(negedge clk_i); enable_i = 1'b0; #1;
         vecs++; if (fwd !== 6'h00 || out_s_last_o !== 1'b0) begin errs++; $display("FAIL en_gate%0d got %h/%b exp 00/0", j, fwd, out_s_last_o); end
         vecs++; if (cnt_out_r_o !== 2 || ready_o !== 1'b0 || done_o !== 1'b0) begin errs++; $display("FAIL en_hold%0d got cnt %0d ready %b done %b exp 2/0/0", j, cnt_out_r_o, ready_o, done_o); end
      end
      for (int k = 2; k < 4; k++) begin
         @(negedge clk_i); enable_i = 1'b1; #1;
         vecs++; if (cnt_out_r_o !== k || fwd !== 6'h3f) begin errs++; $display("FAIL en_resume%0d got %0d/%h exp %0d/3f", k, cnt_out_r_o, fwd, k); end
      end
      @(negedge clk_i); #1;
      vecs++; if (done_o !== 1'b1 || cnt_out_r_o !== 4) begin errs++; $display("FAIL en_done got %b/%0d exp 1/4", done_o, cnt_out_r_o); end
   endtask

   task automatic test_clear;
      clr();
      start_job(4); all_valid(1'b1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i); start_i = 1'b0;
      end
      @(negedge clk_i); clear_i = 1'b1; #1;
      vecs++; if (cnt_out_r_o !== 2 || fwd !== 6'h3f) begin errs++; $display("FAIL clr_pre got %0d/%h exp 2/3f", cnt_out_r_o, fwd); end
      @(negedge clk_i); clear_i = 1'b0; #1;
      vecs++; if (cnt_out_r_o !== 0 || ready_o !== 1'b1 || done_o !== 1'b0 || fwd !== 6'h00) begin errs++; $display("FAIL clr_post got cnt %0d ready %b done %b fwd %h exp 0/1/0/00", cnt_out_r_o, ready_o, done_o, fwd); end
      @(negedge clk_i); #1;
      vecs++; if (done_o !== 1'b0 || cnt_out_r_o !== 0) begin errs++; $display("FAIL clr_nodone got %b/%0d exp 0/0", done_o, cnt_out_r_o); end
   endtask

   task automatic test_reset_midrun;
      clr();
      start_job(4); all_valid(1'b1);
      @(negedge clk_i); start_i = 1'b0;
      @(negedge clk_i); #1;
      vecs++; if (cnt_out_r_o !== 1) begin errs++; $display("FAIL rst_pre got %0d exp 1", cnt_out_r_o); end
      #2 rst_ni = 1'b0; #1;
      vecs++; if (cnt_out_r_o !== 0 || ready_o !== 1'b1 || done_o !== 1'b0 || fwd !== 6'h00) begin errs++; $display("FAIL rst_async got cnt %0d ready %b done %b fwd %h exp 0/1/0/00", cnt_out_r_o, ready_o, done_o, fwd); end
      @(negedge clk_i); rst_ni = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk_i); #1;
         vecs++; if (done_o !== 1'b0 || ready_o !== 1'b1 || cnt_out_r_o !== 0) begin errs++; $display("FAIL rst_after%0d got done %b ready %b cnt %0d exp 0/1/0", j, done_o, ready_o, cnt_out_r_o); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_limit0();
      test_backpressure();
      test_enable_pause();
      test_clear();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
